// File: rtl/dconv_pkg.sv
// Shared definitions for the KxK depthwise-convolution PE: state encoding,
// pipeline depth and the width helpers used to size the accumulator.
package dconv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_K  = 3'd1,
    FILL    = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int PIPE_LAT = 4;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int sumWidth(input int iw, input int ww, input int k);
    return iw + ww + clog2(k * k) + 1;
  endfunction

endpackage

// File: rtl/dconv_round_sat.sv
// Final requantisation stage: round-half-up, arithmetic shift, clamp to the
// output range, and register. Optional macro DCONV_RELU_EN forces negative
// results to zero after saturation without adding a cycle.
module dconv_round_sat
  import dconv_pkg::*;
#(
  parameter int IN_W       = 21,
  parameter int OW         = 8,
  parameter int FRAC_SHIFT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic                   i_last,
  input  logic signed [IN_W-1:0] i_data,
  output logic                   o_valid,
  output logic                   o_last,
  output logic signed [OW-1:0]   o_data
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] ROUND_ADD = RW'((2 ** FRAC_SHIFT) / 2);
  localparam logic signed [RW-1:0] MAX_VAL   = RW'((2 ** (OW - 1)) - 1);
  localparam logic signed [RW-1:0] MIN_VAL   = RW'(-(2 ** (OW - 1)));

  logic signed [RW-1:0] w_rounded;
  logic signed [RW-1:0] w_shifted;
  logic signed [OW-1:0] w_sat;

  // Round, shift and clamp the accumulator into the output range.
  always_comb begin
    w_rounded = RW'(i_data) + ROUND_ADD;
    w_shifted = w_rounded >>> FRAC_SHIFT;
    if (w_shifted > MAX_VAL) begin
      w_sat = MAX_VAL[OW-1:0];
    end else if (w_shifted < MIN_VAL) begin
      w_sat = MIN_VAL[OW-1:0];
    end else begin
      w_sat = w_shifted[OW-1:0];
    end
`ifdef DCONV_RELU_EN
    if (w_sat[OW-1]) begin
      w_sat = '0;
    end
`endif
  end

  // Output register; data holds its last value between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= i_valid;
      o_last  <= i_valid && i_last;
      if (i_valid) begin
        o_data <= w_sat;
      end
    end
  end

endmodule

// File: rtl/dconv_kxk_pe.sv
// KxK depthwise-convolution PE. Loads a kernel column by column, shifts image
// columns through a KxK window and emits one requantised pixel per accepted
// column once the window is full. Optional macro DCONV_RELU_EN (see
// dconv_round_sat) clamps negative outputs to zero.
module dconv_kxk_pe
  import dconv_pkg::*;
#(
  parameter int K          = 3,
  parameter int IW         = 8,
  parameter int WW         = 8,
  parameter int BW         = 16,
  parameter int OW         = 8,
  parameter int FRAC_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [K*WW-1:0] kernel,
  input  logic          kernel_valid,
  input  logic [BW-1:0] bias,
  input  logic [K*IW-1:0] image,
  input  logic          image_valid,
  input  logic          image_last,
  output logic          in_ready,
  output logic [OW-1:0] data_out,
  output logic          output_valid,
  output logic          output_last,
  output logic          short_frame
);

  localparam int SW = sumWidth(IW, WW, K);
  localparam int PW = IW + WW;
  localparam int NT = K * K;

  state_t r_state, w_nextState;
  logic [2:0] r_kernCnt, r_fillCnt, r_drainCnt;
  logic       r_short;

  logic signed [WW-1:0] r_kern  [K][K];
  logic signed [IW-1:0] r_win   [K][K];
  logic signed [BW-1:0] r_bias;
  logic signed [IW-1:0] r_opPix [NT];
  logic signed [WW-1:0] r_opWgt [NT];
  logic signed [PW-1:0] r_prod  [NT];
  logic signed [SW-1:0] r_sum, w_sum;
  logic [3:0] r_vld, r_lst;
  logic signed [OW-1:0] w_dataOut;

  logic w_kernAcc, w_imgAcc, w_fillDone, w_result, w_shortSet;

  // Next state, handshake and acceptance decodes.
  always_comb begin
    in_ready    = (r_state == FILL) || (r_state == COMPUTE);
    w_kernAcc   = kernel_valid && ((r_state == IDLE) || (r_state == LOAD_K));
    w_imgAcc    = image_valid && in_ready;
    w_fillDone  = (r_state == FILL) && (r_fillCnt == 3'(K - 1));
    w_result    = w_imgAcc && (w_fillDone || (r_state == COMPUTE));
    w_shortSet  = w_imgAcc && image_last && (r_state == FILL) && !w_fillDone;
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_kernAcc) w_nextState = LOAD_K;
      LOAD_K:  if (w_kernAcc && (r_kernCnt == 3'(K - 1))) w_nextState = FILL;
      FILL: begin
        if (w_imgAcc && image_last) w_nextState = DRAIN;
        else if (w_imgAcc && w_fillDone) w_nextState = COMPUTE;
      end
      COMPUTE: if (w_imgAcc && image_last) w_nextState = DRAIN;
      DRAIN:   if (r_drainCnt == 3'(PIPE_LAT - 1)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register, column counters, bias capture and short-frame pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_kernCnt  <= '0;
      r_fillCnt  <= '0;
      r_drainCnt <= '0;
      r_bias     <= '0;
      r_short    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_short <= w_shortSet;
      if (r_state == IDLE) begin
        r_kernCnt <= w_kernAcc ? 3'd1 : 3'd0;
      end else if (w_kernAcc) begin
        r_kernCnt <= r_kernCnt + 3'd1;
      end
      if (r_state != FILL) begin
        r_fillCnt <= '0;
      end else if (w_imgAcc) begin
        r_fillCnt <= r_fillCnt + 3'd1;
      end
      r_drainCnt <= (r_state == DRAIN) ? r_drainCnt + 3'd1 : 3'd0;
      if (w_kernAcc && (r_state == IDLE)) begin
        r_bias <= bias;
      end
    end
  end

  // Kernel and image windows: new column enters at 0, oldest falls off K-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < K; c++) begin
        for (int r = 0; r < K; r++) begin
          r_kern[c][r] <= '0;
          r_win[c][r]  <= '0;
        end
      end
    end else begin
      if (w_kernAcc) begin
        for (int c = 1; c < K; c++) begin
          for (int r = 0; r < K; r++) r_kern[c][r] <= r_kern[c-1][r];
        end
        for (int r = 0; r < K; r++) r_kern[0][r] <= kernel[r*WW +: WW];
      end
      if (w_imgAcc) begin
        for (int c = 1; c < K; c++) begin
          for (int r = 0; r < K; r++) r_win[c][r] <= r_win[c-1][r];
        end
        for (int r = 0; r < K; r++) r_win[0][r] <= image[r*IW +: IW];
      end
    end
  end

  // Accumulate all products plus the sign-extended bias.
  always_comb begin
    w_sum = SW'(r_bias);
    for (int i = 0; i < NT; i++) begin
      w_sum = w_sum + SW'(r_prod[i]);
    end
  end

  // Operand, multiply and sum stages with their valid/last tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_lst <= '0;
      r_sum <= '0;
      for (int i = 0; i < NT; i++) begin
        r_opPix[i] <= '0;
        r_opWgt[i] <= '0;
        r_prod[i]  <= '0;
      end
    end else begin
      r_vld <= {r_vld[2:0], w_result};
      r_lst <= {r_lst[2:0], w_result && image_last};
      for (int c = 0; c < K; c++) begin
        for (int r = 0; r < K; r++) begin
          r_opPix[c*K + r] <= r_win[c][r];
          r_opWgt[c*K + r] <= r_kern[c][r];
        end
      end
      for (int i = 0; i < NT; i++) begin
        r_prod[i] <= PW'(r_opPix[i]) * PW'(r_opWgt[i]);
      end
      r_sum <= w_sum;
    end
  end

  dconv_round_sat #(
    .IN_W       (SW),
    .OW         (OW),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_roundSat (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_vld[3]),
    .i_last  (r_lst[3]),
    .i_data  (r_sum),
    .o_valid (output_valid),
    .o_last  (output_last),
    .o_data  (w_dataOut)
  );

  assign data_out    = w_dataOut;
  assign short_frame = r_short;

endmodule

// File: tb/tb_dconv_kxk_pe.sv
// Self-checking bench for dconv_kxk_pe with default parameters. A frame-level
// model (dot product of the last K columns against the kernel in load order)
// predicts every result and its arrival edge. Honours DCONV_RELU_EN.
module tb_dconv_kxk_pe;

  localparam int K  = 3;
  localparam int IW = 8;
  localparam int WW = 8;
  localparam int BW = 16;
  localparam int OW = 8;
  localparam int FS = 4;
`ifdef DCONV_RELU_EN
  localparam int NEG_SAT = 0;
`else
  localparam int NEG_SAT = -128;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [K*WW-1:0] kernel = '0;
  logic kernel_valid = 1'b0;
  logic [BW-1:0] bias = '0;
  logic [K*IW-1:0] image = '0;
  logic image_valid = 1'b0;
  logic image_last = 1'b0;
  logic in_ready, output_valid, output_last, short_frame;
  logic [OW-1:0] data_out;

  typedef struct { int val; bit last; int due; } exp_t;
  typedef struct { int val; bit last; int edgeN; } rcv_t;

  int checks = 0;
  int errors = 0;
  int edgeCnt = 0;
  int shortDue = -100;
  int shortCount = 0;
  bit junkKernel = 1'b0;
  exp_t expQ[$];
  rcv_t rcvQ[$];
  int kl[K][K];
  int biasVal;
  int pixCols[16][K];
  int accEdge[16];
  int seqA[$];

  dconv_kxk_pe #(.K(K), .IW(IW), .WW(WW), .BW(BW), .OW(OW), .FRAC_SHIFT(FS)) dut (
    .clk(clk), .rst_n(rst_n), .kernel(kernel), .kernel_valid(kernel_valid), .bias(bias),
    .image(image), .image_valid(image_valid), .image_last(image_last), .in_ready(in_ready),
    .data_out(data_out), .output_valid(output_valid), .output_last(output_last),
    .short_frame(short_frame)
  );

  // Free-running clock and edge counter used to time expected results.
  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int requant(input longint s);
    longint v;
    v = s + (longint'(1) << FS) / 2;
    v = v >>> FS;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
`ifdef DCONV_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  // Result for the column with frame index n: oldest of the last K columns
  // pairs with the first-loaded kernel column.
  function automatic int modelVal(input int n);
    longint s;
    s = biasVal;
    for (int m = 0; m < K; m++)
      for (int r = 0; r < K; r++)
        s += longint'(pixCols[n-K+1+m][r]) * longint'(kl[m][r]);
    return requant(s);
  endfunction

  // Compare process: every cycle checks short_frame and any result against the model queue.
  always @(negedge clk) begin : cmp
    exp_t e;
    rcv_t rv;
    if (rst_n) begin
      checkOutput("short_frame", int'(short_frame), int'(edgeCnt == shortDue));
      if (short_frame) shortCount++;
      if (output_valid) begin
        rv.val = int'($signed(data_out));
        rv.last = output_last;
        rv.edgeN = edgeCnt;
        rcvQ.push_back(rv);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0d, required no result", rv.val);
        end else begin
          e = expQ.pop_front();
          checkOutput("data_out", rv.val, e.val);
          checkOutput("output_last", int'(rv.last), int'(e.last));
          checkOutput("result_edge", edgeCnt, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setKernel(input int w);
    for (int c = 0; c < K; c++) for (int r = 0; r < K; r++) kl[c][r] = w;
  endtask

  task automatic setPix(input int p);
    for (int n = 0; n < 16; n++) for (int r = 0; r < K; r++) pixCols[n][r] = p;
  endtask

  task automatic loadKernel();
    for (int c = 0; c < K; c++) begin
      for (int r = 0; r < K; r++) kernel[r*WW +: WW] = WW'(kl[c][r]);
      if (c == 0) bias = BW'(biasVal);
      kernel_valid = 1'b1;
      tick();
    end
    kernel_valid = 1'b0;
  endtask

  // Drive one image column and wait (bounded) for it to be accepted.
  task automatic applyStimulus(input int n, input bit last);
    bit acc;
    exp_t e;
    for (int r = 0; r < K; r++) image[r*IW +: IW] = IW'(pixCols[n][r]);
    image_valid = 1'b1;
    image_last = last;
    if (junkKernel) begin
      kernel_valid = 1'b1;
      kernel = K*WW'($urandom);
    end
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = in_ready;
      tick();
    end
    image_valid = 1'b0;
    image_last = 1'b0;
    if (last) kernel_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: column %0d not accepted, required acceptance", n);
    end else begin
      accEdge[n] = edgeCnt;
      if (n >= K - 1) begin
        e.val = modelVal(n);
        e.last = last;
        e.due = edgeCnt + 4;
        expQ.push_back(e);
      end else if (last) begin
        shortDue = edgeCnt;
      end
    end
  endtask

  task automatic runFrame(input int nCols, input int gapMax);
    for (int n = 0; n < nCols; n++) begin
      if (gapMax > 0) repeat ($urandom_range(gapMax, 0)) tick();
      applyStimulus(n, n == nCols - 1);
    end
    repeat (8) tick();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_output_valid"}, int'(output_valid), 0);
    checkOutput({tag, "_data_out"}, int'(data_out), 0);
    checkOutput({tag, "_output_last"}, int'(output_last), 0);
    checkOutput({tag, "_short_frame"}, int'(short_frame), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int biasList[3];
    int expList[3];
    biasList = '{7, 0, -17};
    expList = '{1, 1, 0};

    // Reset state
    repeat (3) tick();
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    tick();

    // Model pins against hand-computed values
    checkOutput("model_basic", requant(144), 9);
    checkOutput("model_bias7", requant(16), 1);
    checkOutput("model_bias0", requant(9), 1);
    checkOutput("model_biasm17", requant(-8), 0);
    checkOutput("model_satpos", requant(9 * 127 * 127), 127);
    checkOutput("model_satneg", requant(-9 * 128 * 127), NEG_SAT);

    // Basic sum: 5 columns of 16, unit weights
    setKernel(1); biasVal = 0; setPix(16);
    rcvQ.delete();
    loadKernel();
    checkOutput("fill_in_ready", int'(in_ready), 1);
    runFrame(5, 0);
    checkOutput("basic_count", rcvQ.size(), 3);
    if (rcvQ.size() == 3) begin
      for (int i = 0; i < 3; i++) checkOutput("basic_value", rcvQ[i].val, 9);
      checkOutput("basic_last_first", int'(rcvQ[0].last), 0);
      checkOutput("basic_last_third", int'(rcvQ[2].last), 1);
      checkOutput("basic_latency", rcvQ[0].edgeN - accEdge[2], 4);
    end
    checkOutput("idle_in_ready", int'(in_ready), 0);

    // Bias and rounding
    for (int b = 0; b < 3; b++) begin
      setKernel(1); biasVal = biasList[b]; setPix(1);
      rcvQ.delete();
      loadKernel();
      runFrame(4, 0);
      checkOutput("bias_count", rcvQ.size(), 2);
      if (rcvQ.size() > 0) checkOutput("bias_value", rcvQ[0].val, expList[b]);
    end

    // Saturation both directions
    setKernel(127); biasVal = 0; setPix(127);
    rcvQ.delete();
    loadKernel();
    runFrame(4, 0);
    if (rcvQ.size() > 0) checkOutput("sat_pos", rcvQ[0].val, 127);
    setKernel(-128);
    rcvQ.delete();
    loadKernel();
    runFrame(4, 0);
    if (rcvQ.size() > 0) checkOutput("sat_neg", rcvQ[0].val, NEG_SAT);

    // Short frame, then a normal frame
    setKernel(1); biasVal = 0; setPix(5);
    rcvQ.delete();
    shortCount = 0;
    loadKernel();
    applyStimulus(0, 1'b0);
    applyStimulus(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_in_ready", int'(in_ready), 0);
      tick();
    end
    repeat (4) tick();
    checkOutput("short_count", shortCount, 1);
    checkOutput("short_no_output", rcvQ.size(), 0);
    setPix(16);
    loadKernel();
    runFrame(5, 0);
    checkOutput("after_short_count", rcvQ.size(), 3);

    // Reset while three results are in flight
    for (int c = 0; c < K; c++) for (int r = 0; r < K; r++) kl[c][r] = c * 3 + r - 4;
    biasVal = 100;
    for (int n = 0; n < 16; n++) for (int r = 0; r < K; r++) pixCols[n][r] = n * 7 - r * 5 - 20;
    rcvQ.delete();
    loadKernel();
    for (int n = 0; n < 5; n++) applyStimulus(n, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expQ.delete();
    shortDue = -100;
    checkIdleOutputs("midreset");
    repeat (8) tick();
    checkOutput("midreset_no_output", rcvQ.size(), 0);
    loadKernel();
    runFrame(6, 0);
    checkOutput("midreset_recover_count", rcvQ.size(), 4);

    // Stalls and ignored kernel strobes must not change results
    for (int c = 0; c < K; c++) for (int r = 0; r < K; r++) kl[c][r] = int'($urandom_range(255, 0)) - 128;
    biasVal = int'($urandom_range(2000, 0)) - 1000;
    for (int n = 0; n < 16; n++) for (int r = 0; r < K; r++) pixCols[n][r] = int'($urandom_range(255, 0)) - 128;
    rcvQ.delete();
    loadKernel();
    runFrame(8, 0);
    seqA.delete();
    foreach (rcvQ[i]) seqA.push_back(rcvQ[i].val);
    checkOutput("stall_ref_count", seqA.size(), 6);
    rcvQ.delete();
    loadKernel();
    runFrame(8, 3);
    checkOutput("stall_gap_count", rcvQ.size(), seqA.size());
    for (int i = 0; i < seqA.size() && i < rcvQ.size(); i++) checkOutput("stall_gap_value", rcvQ[i].val, seqA[i]);
    rcvQ.delete();
    loadKernel();
    junkKernel = 1'b1;
    runFrame(8, 0);
    junkKernel = 1'b0;
    checkOutput("junk_kernel_count", rcvQ.size(), seqA.size());
    for (int i = 0; i < seqA.size() && i < rcvQ.size(); i++) checkOutput("junk_kernel_value", rcvQ[i].val, seqA[i]);

    checkOutput("expected_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
